// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multicycle sequencer and the core datapath.
// The master is the controller; the slave is the datapath and data memory.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic       alu_taken;
    logic       mem_ack;
    logic       ir_write;
    logic       reg_write;
    logic       link_write;
    logic       mem_to_reg;
    logic       mem_req;
    logic       mem_we;
    logic       pc_write;
    logic [1:0] pc_src;

    modport master (
        input  opcode, alu_taken, mem_ack,
        output ir_write, reg_write, link_write, mem_to_reg,
               mem_req, mem_we, pc_write, pc_src
    );

    modport slave (
        output opcode, alu_taken, mem_ack,
        input  ir_write, reg_write, link_write, mem_to_reg,
               mem_req, mem_we, pc_write, pc_src
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the bubble core,
// with a variable-latency data memory handshake, memory timeout trap and retire counter.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    multicycle_controller_if.master bus,
    output logic [2:0]            state,
    output logic                  busy,
    output logic                  err,
    output logic [COUNT_W-1:0]    instr_count
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_STORE = 6'b010001;
    localparam logic [5:0] OP_LOAD  = 6'b010010;
    localparam logic [5:0] OP_JR    = 6'b101000;
    localparam logic [5:0] OP_JAL   = 6'b101001;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t             state_r;
    logic [5:0]         op_q_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic               err_r;
    logic [COUNT_W-1:0] instr_count_r;

    logic       ir_write_s;
    logic       reg_write_s;
    logic       link_write_s;
    logic       mem_to_reg_s;
    logic       mem_req_s;
    logic       mem_we_s;
    logic       pc_write_s;
    logic [1:0] pc_src_s;
    logic       is_store_s;
    logic       is_load_s;

    assign is_store_s = (op_q_r == OP_STORE);
    assign is_load_s  = (op_q_r == OP_LOAD);

    // Datapath strobes decoded from the registered state and latched opcode.
    always_comb begin
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        link_write_s = 1'b0;
        mem_to_reg_s = 1'b0;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 2'b00;
        case (state_r)
            S_FETCH: begin
                ir_write_s = 1'b1;
            end
            S_EXECUTE: begin
                case (op_q_r[5:4])
                    2'b01: begin
                        // Unknown memory-class opcodes retire as a NOP.
                        if (!is_store_s && !is_load_s) begin
                            pc_write_s = 1'b1;
                        end else begin
                            pc_write_s = 1'b0;
                        end
                    end
                    2'b10: begin
                        pc_write_s = 1'b1;
                        if (op_q_r == OP_JR) begin
                            pc_src_s = 2'b10;
                        end else if (op_q_r == OP_JAL) begin
                            link_write_s = 1'b1;
                            pc_src_s     = 2'b01;
                        end else begin
                            pc_src_s = bus.alu_taken ? 2'b01 : 2'b00;
                        end
                    end
                    default: begin
                        pc_write_s = 1'b0;
                    end
                endcase
            end
            S_MEMORY: begin
                mem_req_s = 1'b1;
                mem_we_s  = is_store_s;
                if (bus.mem_ack && is_store_s) begin
                    pc_write_s = 1'b1;
                end else begin
                    pc_write_s = 1'b0;
                end
            end
            S_WRITEBACK: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = is_load_s;
                pc_write_s   = 1'b1;
            end
            default: begin
                ir_write_s = 1'b0;
            end
        endcase
    end

    // Sequencer state, latched opcode, memory wait counter, sticky error and retire count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            op_q_r        <= 6'd0;
            wait_cnt_r    <= '0;
            err_r         <= 1'b0;
            instr_count_r <= '0;
        end else begin
            if (pc_write_s) begin
                instr_count_r <= instr_count_r + COUNT_W'(1);
            end
            case (state_r)
                S_IDLE: begin
                    state_r <= start ? S_FETCH : S_IDLE;
                end
                S_FETCH: begin
                    state_r <= S_DECODE;
                end
                S_DECODE: begin
                    op_q_r  <= bus.opcode;
                    state_r <= (bus.opcode == OP_HALT) ? S_HALT : S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (op_q_r[5:4])
                        2'b00, 2'b11: state_r <= S_WRITEBACK;
                        2'b01: begin
                            if (is_store_s || is_load_s) begin
                                state_r <= S_MEMORY;
                            end else begin
                                err_r   <= 1'b1;
                                state_r <= S_FETCH;
                            end
                        end
                        default: state_r <= S_FETCH;
                    endcase
                end
                S_MEMORY: begin
                    // An ack arriving on the timeout cycle still completes the access.
                    if (bus.mem_ack) begin
                        wait_cnt_r <= '0;
                        state_r    <= is_store_s ? S_FETCH : S_WRITEBACK;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        wait_cnt_r <= '0;
                        err_r      <= 1'b1;
                        state_r    <= S_HALT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                S_WRITEBACK: begin
                    state_r <= S_FETCH;
                end
                S_HALT: begin
                    state_r <= S_HALT;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ir_write   = ir_write_s;
    assign bus.reg_write  = reg_write_s;
    assign bus.link_write = link_write_s;
    assign bus.mem_to_reg = mem_to_reg_s;
    assign bus.mem_req    = mem_req_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.pc_write   = pc_write_s;
    assign bus.pc_src     = pc_src_s;

    assign state       = state_r;
    assign busy        = (state_r != S_IDLE) && (state_r != S_HALT);
    assign err         = err_r;
    assign instr_count = instr_count_r;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller with hand-computed expectations.
module tb_multicycle_controller;
    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  state;
    logic        busy;
    logic        err;
    logic [15:0] instr_count;

    int n_checks;
    int n_errors;

    multicycle_controller_if bus();

    multicycle_controller #(.MEM_TIMEOUT(15), .COUNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .state       (state),
        .busy        (busy),
        .err         (err),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        start         = 1'b0;
        bus.opcode    = 6'd0;
        bus.alu_taken = 1'b0;
        bus.mem_ack   = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // ALU instruction: FETCH, DECODE, EXECUTE, WRITEBACK, FETCH
        bus.opcode = 6'b000001;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("alu_fetch", 32'(state), 32'd1);
        check("alu_ir_write", 32'(bus.ir_write), 32'd1);
        check("alu_fetch_pcw", 32'(bus.pc_write), 32'd0);
        tick();
        check("alu_decode", 32'(state), 32'd2);
        tick();
        check("alu_exec", 32'(state), 32'd3);
        check("alu_exec_regw", 32'(bus.reg_write), 32'd0);
        check("alu_exec_pcw", 32'(bus.pc_write), 32'd0);
        tick();
        check("alu_wb", 32'(state), 32'd5);
        check("alu_wb_regw", 32'(bus.reg_write), 32'd1);
        check("alu_wb_pcw", 32'(bus.pc_write), 32'd1);
        check("alu_wb_m2r", 32'(bus.mem_to_reg), 32'd0);
        check("alu_wb_busy", 32'(busy), 32'd1);
        tick();
        check("alu_next_fetch", 32'(state), 32'd1);
        check("alu_count", 32'(instr_count), 32'd1);

        // Load with ack on the third MEMORY cycle: 7 cycles total
        bus.opcode = 6'b010010;
        tick();
        tick();
        tick();
        check("ld_mem1", 32'(state), 32'd4);
        check("ld_mem_req", 32'(bus.mem_req), 32'd1);
        check("ld_mem_we", 32'(bus.mem_we), 32'd0);
        tick();
        tick();
        bus.mem_ack = 1'b1;
        check("ld_mem3", 32'(state), 32'd4);
        tick();
        bus.mem_ack = 1'b0;
        check("ld_wb", 32'(state), 32'd5);
        check("ld_wb_m2r", 32'(bus.mem_to_reg), 32'd1);
        check("ld_wb_regw", 32'(bus.reg_write), 32'd1);
        check("ld_wb_req", 32'(bus.mem_req), 32'd0);
        tick();
        check("ld_fetch", 32'(state), 32'd1);
        check("ld_count", 32'(instr_count), 32'd2);

        // Conditional branch taken then not taken: 3 cycles each
        bus.opcode = 6'b100001;
        bus.alu_taken = 1'b1;
        tick();
        tick();
        check("br_t_exec", 32'(state), 32'd3);
        check("br_t_pcw", 32'(bus.pc_write), 32'd1);
        check("br_t_src", 32'(bus.pc_src), 32'd1);
        check("br_t_regw", 32'(bus.reg_write), 32'd0);
        tick();
        check("br_t_fetch", 32'(state), 32'd1);
        bus.alu_taken = 1'b0;
        tick();
        tick();
        check("br_n_src", 32'(bus.pc_src), 32'd0);
        check("br_n_pcw", 32'(bus.pc_write), 32'd1);
        check("br_n_regw", 32'(bus.reg_write), 32'd0);
        tick();
        check("br_n_fetch", 32'(state), 32'd1);
        check("br_count", 32'(instr_count), 32'd4);

        // jal then jr
        bus.opcode = 6'b101001;
        tick();
        tick();
        check("jal_link", 32'(bus.link_write), 32'd1);
        check("jal_src", 32'(bus.pc_src), 32'd1);
        tick();
        bus.opcode = 6'b101000;
        tick();
        tick();
        check("jr_src", 32'(bus.pc_src), 32'd2);
        check("jr_link", 32'(bus.link_write), 32'd0);
        check("jr_pcw", 32'(bus.pc_write), 32'd1);
        tick();
        check("jr_fetch", 32'(state), 32'd1);
        check("jmp_count", 32'(instr_count), 32'd6);

        // Immediate-class ALU goes through WRITEBACK
        bus.opcode = 6'b110011;
        tick();
        tick();
        tick();
        check("imm_wb", 32'(state), 32'd5);
        check("imm_wb_regw", 32'(bus.reg_write), 32'd1);
        tick();
        check("imm_count", 32'(instr_count), 32'd7);

        // Store acked in its first MEMORY cycle: 4 cycles
        bus.opcode = 6'b010001;
        tick();
        tick();
        tick();
        check("st_mem", 32'(state), 32'd4);
        check("st_mem_we", 32'(bus.mem_we), 32'd1);
        check("st_pcw_noack", 32'(bus.pc_write), 32'd0);
        bus.mem_ack = 1'b1;
        #1;
        check("st_pcw_ack", 32'(bus.pc_write), 32'd1);
        tick();
        bus.mem_ack = 1'b0;
        check("st_fetch", 32'(state), 32'd1);
        check("st_count", 32'(instr_count), 32'd8);

        // Store that never acks: 15 MEMORY cycles then HALT with err
        check("to_err_before", 32'(err), 32'd0);
        tick();
        tick();
        tick();
        for (int i = 0; i < 15; i++) begin
            check($sformatf("to_req_%0d", i), 32'(bus.mem_req), 32'd1);
            tick();
        end
        check("to_state", 32'(state), 32'd6);
        check("to_err", 32'(err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_req_off", 32'(bus.mem_req), 32'd0);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        check("halt_start_ign", 32'(state), 32'd6);
        check("halt_count", 32'(instr_count), 32'd8);

        // Reset, then an undefined memory-class opcode retires as NOP and sets err
        rst = 1'b1;
        #2;
        rst = 1'b0;
        check("rst2_err", 32'(err), 32'd0);
        bus.opcode = 6'b010000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ill_exec", 32'(state), 32'd3);
        check("ill_pcw", 32'(bus.pc_write), 32'd1);
        check("ill_src", 32'(bus.pc_src), 32'd0);
        check("ill_req", 32'(bus.mem_req), 32'd0);
        tick();
        check("ill_fetch", 32'(state), 32'd1);
        check("ill_err", 32'(err), 32'd1);
        check("ill_count", 32'(instr_count), 32'd1);

        // Asynchronous reset in the middle of a load
        bus.opcode = 6'b010010;
        tick();
        tick();
        tick();
        check("ar_mem", 32'(state), 32'd4);
        check("ar_req_before", 32'(bus.mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_req", 32'(bus.mem_req), 32'd0);
        check("ar_state", 32'(state), 32'd0);
        check("ar_count", 32'(instr_count), 32'd0);
        check("ar_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Halt opcode stops in DECODE without flagging an error
        bus.opcode = 6'b111111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("hlt_state", 32'(state), 32'd6);
        check("hlt_err", 32'(err), 32'd0);
        check("hlt_busy", 32'(busy), 32'd0);
        check("hlt_count", 32'(instr_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
